// File: rtl/serial_loader.sv
// serial_loader: loads Hack instruction memory from a chip-select-framed serial stream,
// assembling 16-bit words through an external shift register and holding the CPU in reset per frame.
module serial_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              sck_i,
    input  logic              sdi_i,
    input  logic              cs_n_i,
    output logic              shift_in_o,
    output logic              shift_en_o,
    input  logic [15:0]       shift_word_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_data_o,
    output logic              mem_we_o,
    input  logic              mem_ack_i,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              addr_ovf_o
);
    typedef enum logic [2:0] {IDLE, RECV, WAIT_SR, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        sck_q, sdi_q, cs_q;
    logic              sck_rise_q, cs_rise_q, cs_fall_q;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              addr_ovf_q, addr_ovf_d;
    logic              cs_pend_q, cs_pend_d;
    logic              shift_en;
    logic              cs_pend;

    // Two synchroniser stages, a third copy for edge detection, then a registered edge strobe.
    // sdi runs through the same depth so it lines up with the sck edge strobe.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sck_q      <= '0;
            sdi_q      <= '0;
            cs_q       <= '1;
            sck_rise_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
        end else begin
            sck_q      <= {sck_q[1:0], sck_i};
            sdi_q      <= {sdi_q[1:0], sdi_i};
            cs_q       <= {cs_q[1:0], cs_n_i};
            sck_rise_q <= sck_q[1] & ~sck_q[2];
            cs_rise_q  <= cs_q[1] & ~cs_q[2];
            cs_fall_q  <= ~cs_q[1] & cs_q[2];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            addr_ovf_q  <= 1'b0;
            cs_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            addr_ovf_q  <= addr_ovf_d;
            cs_pend_q   <= cs_pend_d;
        end
    end

    assign cs_pend = cs_pend_q | cs_rise_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        addr_ovf_d  = addr_ovf_q;
        cs_pend_d   = cs_pend_q;
        shift_en    = 1'b0;
        case (state_q)
            IDLE: begin
                cs_pend_d = 1'b0;
                if (cs_fall_q) begin
                    state_d     = RECV;
                    bit_cnt_d   = '0;
                    addr_d      = '0;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                    overrun_d   = 1'b0;
                    addr_ovf_d  = 1'b0;
                end
            end
            RECV: begin
                if (cs_rise_q) begin
                    frame_err_d = frame_err_q | (bit_cnt_q != 4'd0);
                    state_d     = DONE;
                end else if (sck_rise_q) begin
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = (bit_cnt_q == 4'd15) ? WAIT_SR : RECV;
                end
            end
            WAIT_SR: begin
                data_d    = shift_word_i;
                overrun_d = overrun_q | sck_rise_q;
                cs_pend_d = cs_pend;
                if (cnt_q == FULL) begin
                    addr_ovf_d = 1'b1;
                    state_d    = cs_pend ? DONE : RECV;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                overrun_d = overrun_q | sck_rise_q;
                cs_pend_d = cs_pend;
                if (mem_ack_i) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + (ADDR_W+1)'(1);
                    state_d = cs_pend ? DONE : RECV;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign shift_en_o  = shift_en;
    assign shift_in_o  = shift_en & sdi_q[2];
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign mem_we_o    = state_q == WRITE;
    assign cpu_hold_o  = state_q inside {RECV, WAIT_SR, WRITE};
    assign done_o      = state_q == DONE;
    assign word_cnt_o  = cnt_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign addr_ovf_o  = addr_ovf_q;
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: random and directed frames against a word-level model of the loader.
module tb_serial_loader;
    localparam int AW = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0, resetb = 1'b0;
    logic          sck_i = 1'b0, sdi_i = 1'b0, cs_n_i = 1'b1, mem_ack_i = 1'b0;
    logic          shift_in_o, shift_en_o, mem_we_o, cpu_hold_o, done_o;
    logic          frame_err_o, overrun_o, addr_ovf_o;
    logic [15:0]   shift_word_i = '0, mem_data_o;
    logic [AW-1:0] mem_addr_o;
    logic [AW:0]   word_cnt_o;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, ack_delay = 0, we_age = 0;
    int n_pulse, n_done, hold_viol;
    int first_rise_cyc, first_pulse_cyc, last_pulse_cyc, first_we_cyc;
    bit we_pend = 1'b0;
    logic [AW-1:0] pend_addr;
    logic [15:0]   pend_data;
    bit            rx_bits[$], exp_bits[$];
    logic [AW-1:0] wr_addr[$];
    logic [15:0]   wr_data[$];
    logic [15:0]   tx_words[$];

    serial_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .resetb(resetb), .sck_i(sck_i), .sdi_i(sdi_i), .cs_n_i(cs_n_i),
        .shift_in_o(shift_in_o), .shift_en_o(shift_en_o), .shift_word_i(shift_word_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
        .mem_ack_i(mem_ack_i), .cpu_hold_o(cpu_hold_o), .done_o(done_o),
        .word_cnt_o(word_cnt_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
        .addr_ovf_o(addr_ovf_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // External 16-bit shift register fed by the loader
    always @(posedge clk) if (shift_en_o) shift_word_i <= {shift_word_i[14:0], shift_in_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory responder and bus monitor, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        we_age = mem_we_o ? we_age + 1 : 0;
        mem_ack_i = mem_we_o && (we_age > ack_delay);
        if (resetb && we_pend && (!mem_we_o || mem_addr_o != pend_addr || mem_data_o != pend_data))
            hold_viol++;
        we_pend = mem_we_o && !mem_ack_i;
        pend_addr = mem_addr_o;
        pend_data = mem_data_o;
        if (shift_en_o) begin
            rx_bits.push_back(shift_in_o);
            if (n_pulse == 0) first_pulse_cyc = cyc;
            last_pulse_cyc = cyc;
            n_pulse++;
        end
        if (mem_we_o && first_we_cyc < 0) first_we_cyc = cyc;
        if (mem_we_o && mem_ack_i) begin
            wr_addr.push_back(mem_addr_o);
            wr_data.push_back(mem_data_o);
        end
        if (done_o) n_done++;
    end

    task automatic clear_mon();
        rx_bits.delete(); exp_bits.delete(); wr_addr.delete(); wr_data.delete();
        n_pulse = 0; n_done = 0; hold_viol = 0;
        first_rise_cyc = -1; first_pulse_cyc = -1; last_pulse_cyc = -1; first_we_cyc = -1;
    endtask

    task automatic send_bit(input bit b);
        sdi_i = b;
        tick(2);
        sck_i = 1'b1;
        if (first_rise_cyc < 0) first_rise_cyc = cyc;
        tick(4);
        sck_i = 1'b0;
        tick(2);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i]);
            exp_bits.push_back(w[i]);
        end
    endtask

    // Sends tx_words, then 'extra' loose bits; ovr injects one bit while the first write is pending
    task automatic run_frame(input string nm, input int extra, input int delay, input bit ovr);
        int nw, nexp, t, bad;
        bit b;
        nw = tx_words.size();
        nexp = (nw > DEPTH) ? DEPTH : nw;
        ack_delay = delay;
        clear_mon();
        cs_n_i = 1'b0;
        tick(6);
        check($sformatf("%s_start_clr", nm), {frame_err_o, overrun_o, addr_ovf_o, word_cnt_o}, 0);
        check($sformatf("%s_hold", nm), cpu_hold_o, 1);
        for (int i = 0; i < nw; i++) begin
            send_word(tx_words[i]);
            if (ovr && i == 0) send_bit(1'($urandom_range(0, 1)));
            tick(delay + 12);
        end
        for (int e = 0; e < extra; e++) begin
            b = 1'($urandom_range(0, 1));
            send_bit(b);
            exp_bits.push_back(b);
        end
        tick(4);
        cs_n_i = 1'b1;
        t = 0;
        while (n_done == 0 && t < 60) begin
            tick(1);
            t++;
        end
        tick(4);
        check($sformatf("%s_done_cnt", nm), n_done, 1);
        check($sformatf("%s_nwr", nm), wr_addr.size(), nexp);
        for (int i = 0; i < wr_addr.size() && i < nexp; i++) begin
            check($sformatf("%s_wa%0d", nm, i), wr_addr[i], i % DEPTH);
            check($sformatf("%s_wd%0d", nm, i), wr_data[i], tx_words[i]);
        end
        check($sformatf("%s_wcnt", nm), word_cnt_o, nexp);
        check($sformatf("%s_ferr", nm), frame_err_o, extra != 0);
        check($sformatf("%s_ovr", nm), overrun_o, ovr);
        check($sformatf("%s_aovf", nm), addr_ovf_o, nw > DEPTH);
        check($sformatf("%s_pulses", nm), n_pulse, 16 * nw + extra);
        bad = (rx_bits.size() != exp_bits.size());
        if (!bad) foreach (rx_bits[i]) if (rx_bits[i] != exp_bits[i]) bad++;
        check($sformatf("%s_bits_bad", nm), bad, 0);
        check($sformatf("%s_we_hold_viol", nm), hold_viol, 0);
        check($sformatf("%s_idle", nm), {cpu_hold_o, mem_we_o, done_o}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        logic [15:0] w;
        clear_mon();
        tick(3);
        check("rst_ctrl", {shift_en_o, shift_in_o, mem_we_o, cpu_hold_o, done_o,
                           frame_err_o, overrun_o, addr_ovf_o}, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", mem_data_o, 0);
        check("rst_wcnt", word_cnt_o, 0);
        resetb = 1'b1;
        tick(5);

        tx_words = '{16'hA5C3};
        run_frame("single", 0, 0, 1'b0);
        check("sck_latency", first_pulse_cyc - first_rise_cyc, 3);
        check("we_latency", first_we_cyc - last_pulse_cyc, 2);

        tx_words = '{16'h0001, 16'h8000, 16'hFFFF};
        run_frame("multi", 0, 4, 1'b0);

        tx_words = '{16'h1234};
        run_frame("partial", 5, 0, 1'b0);

        tx_words = '{16'($urandom)};
        run_frame("overrun", 0, 30, 1'b1);

        tx_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        run_frame("full", 0, 1, 1'b0);

        for (int r = 0; r < 5; r++) begin
            tx_words.delete();
            repeat ($urandom_range(1, 6)) tx_words.push_back(16'($urandom));
            run_frame($sformatf("rnd%0d", r), $urandom_range(0, 1) * $urandom_range(1, 15),
                      $urandom_range(0, 6), 1'b0);
        end

        ack_delay = 40;
        clear_mon();
        cs_n_i = 1'b0;
        tick(6);
        w = 16'($urandom);
        send_word(w);
        t = 0;
        while (!mem_we_o && t < 30) begin
            tick(1);
            t++;
        end
        check("rst_mid_we_seen", mem_we_o, 1);
        #2 resetb = 1'b0;
        #1;
        check("rst_mid_outs", {mem_we_o, cpu_hold_o, shift_en_o, done_o}, 0);
        tick(2);
        cs_n_i = 1'b1;
        tick(2);
        resetb = 1'b1;
        tick(10);
        check("rst_mid_nwr", wr_addr.size(), 0);
        check("rst_mid_ndone", n_done, 0);
        check("rst_mid_wcnt", word_cnt_o, 0);

        tx_words = '{16'hBEEF, 16'h0F0F};
        run_frame("after_rst", 0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_loader.md
# serial_loader

Serial program loader for the Hack CPU instruction memory. It receives a chip-select-framed serial bitstream from an external host and drives the 16-bit shift register's serial input and enable one bit per sampled serial-clock edge. After every 16th bit it takes the assembled word from the shift register's parallel output and writes it to instruction memory at an auto-incrementing address, using a write/acknowledge handshake. The CPU is held in reset for the whole frame.

## Interface
Parameters:
- ADDR_W, default 15: instruction memory address width; maximum word count is 2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- resetb  input  1  asynchronous, active-low reset.
- sck_i  input  1  host serial clock, asynchronous to clk; data is sampled on its rising edge.
- sdi_i  input  1  host serial data, MSB first, asynchronous.
- cs_n_i  input  1  host frame select, active low, asynchronous.
- shift_in_o  output  1  serial bit to the shift register.
- shift_en_o  output  1  one-cycle shift strobe to the shift register.
- shift_word_i  input  16  parallel output of the shift register.
- mem_addr_o  output  ADDR_W  write address.
- mem_data_o  output  16  write data.
- mem_we_o  output  1  write request; held high until acknowledged.
- mem_ack_i  input  1  write accepted; sampled only while mem_we_o=1.
- cpu_hold_o  output  1  holds the CPU in reset while a frame is active.
- done_o  output  1  one-cycle pulse at the end of a frame.
- word_cnt_o  output  ADDR_W+1  number of words written in the current or last frame.
- frame_err_o  output  1  sticky flag: frame ended with a partial word.
- overrun_o  output  1  sticky flag: a bit arrived while a write was pending.
- addr_ovf_o  output  1  sticky flag: a word arrived after memory was full.

## Operation
- Synchronisation: sck_i, sdi_i and cs_n_i each pass through a 2-flop synchroniser. Edges are detected on the synchronised sck and cs_n using a third registered copy.
- States:
  - IDLE: on a cs_n falling edge, go to RECV. Clear mem_addr_o, word_cnt_o, the bit counter and all sticky flags. Set cpu_hold_o=1.
  - RECV: on each sck rising edge, drive shift_en_o=1 for one cycle with shift_in_o set to the synchronised sdi. Increment the 4-bit bit counter.
    - On the 16th bit (counter wraps 15->0), go to WAIT_SR.
    - On a cs_n rising edge with the bit counter at 0, go to DONE.
    - On a cs_n rising edge with the bit counter nonzero, set frame_err_o and go to DONE. The partial word is discarded.
  - WAIT_SR: lasts one cycle so the shift register can update. Capture shift_word_i into mem_data_o. If word_cnt_o equals 2^ADDR_W, set addr_ovf_o and return to RECV without writing. Otherwise go to WRITE.
  - WRITE: mem_we_o=1 with stable mem_addr_o and mem_data_o. In the cycle where mem_ack_i=1, the write completes. On the next cycle: mem_we_o=0, mem_addr_o increments (wrapping to 0 after the maximum), word_cnt_o increments, and the state goes to RECV, or to DONE if a cs_n rise was latched.
  - DONE: one cycle. done_o=1 and cpu_hold_o=0. Then go to IDLE.
- An sck edge during WAIT_SR or WRITE sets overrun_o. The bit is dropped and shift_en_o stays 0.
- A cs_n rise during WAIT_SR or WRITE is latched. The pending write finishes before the block enters DONE.
- A cs_n fall outside IDLE is ignored.
- shift_en_o is never high in any state except RECV.

## Timing
- Reset values: every output is 0. The state is IDLE. The bit counter is 0.
- Input latency: a pin-level sck rise produces a shift_en_o pulse 3 clk cycles later (2 synchroniser cycles plus 1 edge-detect cycle).
- Write sequence: if the 16th shift_en_o pulse occurs in cycle T:
  - WAIT_SR is in cycle T+1, where shift_word_i is valid.
  - mem_we_o rises in cycle T+2.
  - With mem_ack_i already high, the write completes in T+2 and the address increments in T+3.
- Host constraint: each sck high phase and low phase must be at least 3 clk cycles. The gap between the last bit of a word and the first bit of the next must cover the memory acknowledge latency plus 3 cycles; otherwise overrun_o is set.
- done_o: occurs exactly 1 cycle after leaving RECV or WRITE on frame end, and lasts 1 cycle.
- Reset mid-frame: the block returns to reset values immediately. No write completes, and no done_o pulse is produced.

## Test plan
- Reset: assert resetb=0 mid-WRITE -> mem_we_o, cpu_hold_o and shift_en_o are 0 immediately; the block then returns to IDLE.
- Single word: send 0xA5C3 MSB first with mem_ack_i tied to 1 -> exactly 16 shift_en_o pulses; one write of 0xA5C3 at address 0; word_cnt_o=1; a done_o pulse after the cs_n rise; no error flags.
- Multi-word with a slow acknowledge: send 3 words 0x0001, 0x8000, 0xFFFF with mem_ack_i delayed 4 cycles -> writes at addresses 0, 1, 2; mem_we_o held high until each ack; word_cnt_o=3.
- Partial frame: send 0x1234 followed by 5 more bits, then raise cs_n -> exactly one write; frame_err_o=1; done_o pulses. The flag clears on the next cs_n fall.
- Overrun: send a sck edge while mem_ack_i is held low in WRITE -> overrun_o=1, no shift_en_o pulse for that bit, and the pending write still completes.
- Full memory: with ADDR_W=2, send 5 words -> 4 writes at addresses 0-3; the 5th word is not written; addr_ovf_o=1; word_cnt_o=4.
